// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared loader state encoding and ALU opcode constants
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_OPW     = 3;
  localparam int ALU_NUM_OPS = 6;

  typedef enum logic [1:0] {
    S_OP     = 2'd0,
    S_A      = 2'd1,
    S_B      = 2'd2,
    S_COMMIT = 2'd3
  } ld_state_e;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OPW-1:0] OP_NOT = 3'd5;

endpackage
`default_nettype wire

// File: rtl/alu_operand_loader_en_reg.sv
`default_nettype none
// ============================================================================
// alu_operand_loader_en_reg : load-enable register for one staged field
// Rev 1.0
// ============================================================================
module alu_operand_loader_en_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (i_en) data_d = i_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign o_q = data_q;

endmodule
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// alu_operand_loader : assembles opcode/A/B word frames and issues a
// one-cycle load pulse to the ALU register bank when it is ready.
// Rev 1.0
// ============================================================================
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int OPW     = ALU_OPW,
  parameter int NUM_OPS = ALU_NUM_OPS
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] In_data,
  output logic             In_ready,
  input  logic             Abort,
  input  logic             Alu_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [OPW-1:0]   Op_out,
  output logic             Load_en,
  output logic             Err,
  output logic [7:0]       Frame_cnt
);

  ld_state_e      state_q, state_d;
  logic           load_en_q, load_en_d;
  logic           err_q, err_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           accept;
  logic           op_legal;
  logic           op_en, a_en, b_en;
  logic [OPW-1:0] op_field;

  assign In_ready = (state_q != S_COMMIT);
  assign accept   = In_valid && In_ready && !Abort;
  assign op_field = In_data[OPW-1:0];
  // Zero-extend so the bound compares correctly even when NUM_OPS == 2**OPW
  assign op_legal = ({{(32-OPW){1'b0}}, op_field} < 32'(NUM_OPS));

  always_comb begin
    state_d     = state_q;
    load_en_d   = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    op_en       = 1'b0;
    a_en        = 1'b0;
    b_en        = 1'b0;
    if (Abort) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP: begin
          if (accept) begin
            if (op_legal) begin
              op_en   = 1'b1;
              state_d = S_A;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_A: begin
          if (accept) begin
            a_en    = 1'b1;
            state_d = S_B;
          end
        end
        S_B: begin
          if (accept) begin
            b_en    = 1'b1;
            state_d = S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (Alu_ready) begin
            load_en_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = S_OP;
          end
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_OP;
      load_en_q   <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      load_en_q   <= load_en_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  alu_operand_loader_en_reg #(.W(OPW)) u_op_reg (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_en  (op_en),
    .i_d   (op_field),
    .o_q   (Op_out)
  );

  alu_operand_loader_en_reg #(.W(WIDTH)) u_a_reg (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_en  (a_en),
    .i_d   (In_data),
    .o_q   (A_out)
  );

  alu_operand_loader_en_reg #(.W(WIDTH)) u_b_reg (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_en  (b_en),
    .i_d   (In_data),
    .o_q   (B_out)
  );

  assign Load_en   = load_en_q;
  assign Err       = err_q;
  assign Frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_alu_operand_loader : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
module tb_alu_operand_loader;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       In_valid;
  logic [3:0] In_data;
  logic       In_ready;
  logic       Abort;
  logic       Alu_ready;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic [2:0] Op_out;
  logic       Load_en;
  logic       Err;
  logic [7:0] Frame_cnt;

  int checks   = 0;
  int failures = 0;

  alu_operand_loader #(.WIDTH(4), .OPW(3), .NUM_OPS(6)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_data   (In_data),
    .In_ready  (In_ready),
    .Abort     (Abort),
    .Alu_ready (Alu_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .Op_out    (Op_out),
    .Load_en   (Load_en),
    .Err       (Err),
    .Frame_cnt (Frame_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       ab;
    logic       ar;
    logic       rdy;
    logic       le;
    logic       err;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] d, input logic ab, input logic ar,
                     input logic rdy, input logic le, input logic err, input logic [2:0] op,
                     input logic [3:0] a, input logic [3:0] b, input logic [7:0] cnt);
    vec_t t;
    t = '{v: v, d: d, ab: ab, ar: ar, rdy: rdy, le: le, err: err, op: op, a: a, b: b, cnt: cnt};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic ab, input logic ar);
    In_valid  = v;
    In_data   = d;
    Abort     = ab;
    Alu_ready = ar;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic le, input logic err,
                         input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] cnt);
    chk({tag, ".in_ready"}, {7'd0, In_ready}, {7'd0, rdy});
    chk({tag, ".load_en"},  {7'd0, Load_en},  {7'd0, le});
    chk({tag, ".err"},      {7'd0, Err},      {7'd0, err});
    chk({tag, ".op_out"},   {5'd0, Op_out},   {5'd0, op});
    chk({tag, ".a_out"},    {4'd0, A_out},    {4'd0, a});
    chk({tag, ".b_out"},    {4'd0, B_out},    {4'd0, b});
    chk({tag, ".frame_cnt"}, Frame_cnt, cnt);
  endtask

  task automatic async_reset_pulse();
    #2 Rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cnt_m;
    logic [2:0] op_m;
    logic [3:0] a_m, b_m;

    //   v  d   ab ar | rdy le err op a  b  cnt
    add(1, 3,  0, 1,   1, 0, 0, 3, 0, 0, 1'b0);
    add(1, 5,  0, 1,   1, 0, 0, 3, 5, 0, 0);
    add(1, 9,  0, 1,   0, 0, 0, 3, 5, 9, 0);
    add(0, 0,  0, 1,   1, 1, 0, 3, 5, 9, 1);
    add(0, 0,  0, 1,   1, 0, 0, 3, 5, 9, 1);
    add(1, 7,  0, 1,   1, 0, 1, 3, 5, 9, 1);
    add(0, 0,  0, 1,   1, 0, 0, 3, 5, 9, 1);
    add(1, 10, 0, 1,   1, 0, 0, 2, 5, 9, 1);
    add(1, 1,  0, 1,   1, 0, 0, 2, 1, 9, 1);
    add(1, 1,  0, 1,   0, 0, 0, 2, 1, 1, 1);
    add(0, 0,  0, 1,   1, 1, 0, 2, 1, 1, 2);
    add(1, 6,  0, 1,   1, 0, 1, 2, 1, 1, 2);
    add(1, 14, 0, 1,   1, 0, 1, 2, 1, 1, 2);
    add(1, 1,  0, 0,   1, 0, 0, 1, 1, 1, 2);
    add(1, 4,  0, 0,   1, 0, 0, 1, 4, 1, 2);
    add(1, 4,  0, 0,   0, 0, 0, 1, 4, 4, 2);
    for (int i = 0; i < 5; i++)
      add(1, 15, 0, 0, 0, 0, 0, 1, 4, 4, 2);
    add(0, 0,  0, 1,   1, 1, 0, 1, 4, 4, 3);
    add(0, 0,  0, 1,   1, 0, 0, 1, 4, 4, 3);
    add(1, 0,  0, 1,   1, 0, 0, 0, 4, 4, 3);
    add(1, 6,  0, 1,   1, 0, 0, 0, 6, 4, 3);
    add(1, 6,  1, 1,   1, 0, 0, 0, 6, 4, 3);
    add(0, 0,  0, 1,   1, 0, 0, 0, 6, 4, 3);
    add(1, 2,  1, 1,   1, 0, 0, 0, 6, 4, 3);
    add(1, 5,  0, 1,   1, 0, 0, 5, 6, 4, 3);
    add(1, 5,  0, 1,   1, 0, 0, 5, 5, 4, 3);
    add(1, 7,  0, 1,   0, 0, 0, 5, 5, 7, 3);
    add(0, 0,  1, 1,   1, 0, 0, 5, 5, 7, 3);
    add(0, 0,  0, 1,   1, 0, 0, 5, 5, 7, 3);
    add(1, 7,  1, 1,   1, 0, 0, 5, 5, 7, 3);
    add(1, 2,  0, 1,   1, 0, 0, 2, 5, 7, 3);

    Rst_n = 1'b0; In_valid = 1'b0; In_data = 4'd0; Abort = 1'b0; Alu_ready = 1'b0;
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].ab, vecs[i].ar);
      chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].le, vecs[i].err,
              vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cnt);
    end

    // Mid-frame asynchronous reset while in S_B
    drive(1, 4'd3, 0, 1);
    chk_all("pre_reset", 1'b1, 1'b0, 1'b0, 3'd2, 4'd3, 4'd7, 8'd3);
    async_reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'd0, 0, 1);
      chk_all($sformatf("post_reset%0d", i), 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    end
    drive(1, 4'd1, 0, 1);
    drive(1, 4'd2, 0, 1);
    drive(1, 4'd3, 0, 1);
    drive(0, 4'd0, 0, 1);
    chk_all("fresh_frame", 1'b1, 1'b1, 1'b0, 3'd1, 4'd2, 4'd3, 8'd1);

    // 256 back-to-back frames, In_valid held high
    drive(0, 4'd0, 0, 1);
    async_reset_pulse();
    cnt_m = 8'd0;
    for (int f = 0; f < 256; f++) begin
      op_m = 3'(f % 6);
      a_m  = 4'(f % 16);
      b_m  = 4'((f * 3) % 16);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       drive(1, {1'b1, op_m}, 0, 1);
          1:       drive(1, a_m, 0, 1);
          2:       drive(1, b_m, 0, 1);
          default: drive(1, 4'hF, 0, 1);
        endcase
        chk("b2b.load_en", {7'd0, Load_en}, {7'd0, (k == 3)});
        chk("b2b.in_ready", {7'd0, In_ready}, {7'd0, (k != 2)});
        if (k == 3) begin
          cnt_m = cnt_m + 8'd1;
          chk("b2b.frame_cnt", Frame_cnt, cnt_m);
          chk("b2b.op_out", {5'd0, Op_out}, {5'd0, op_m});
          chk("b2b.a_out", {4'd0, A_out}, {4'd0, a_m});
          chk("b2b.b_out", {4'd0, B_out}, {4'd0, b_m});
        end
      end
      if (f == 254) chk("b2b.cnt255", Frame_cnt, 8'd255);
    end
    chk("b2b.wrap", Frame_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Writer-side front end for the ALU operand/opcode registers. It accepts a word stream over a valid/ready handshake and assembles each three-word frame: opcode, then operand A, then operand B. It then presents the staged values together with a single-cycle load-enable pulse to the downstream registers and ALU. The enable pulse is issued only when the downstream side is ready. Sits between the host/testbench stimulus port and the register bank that feeds the ALU.

Parameters:
WIDTH, 4, data word and operand width in bits
OPW, 3, opcode width in bits (OPW <= WIDTH; opcode taken from In_data[OPW-1:0])
NUM_OPS, 6, number of legal opcodes; opcodes >= NUM_OPS are illegal

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous, active-low reset
In_valid  input  1  upstream word valid
In_data  input  WIDTH  upstream word
In_ready  output  1  loader can accept a word this cycle
Abort  input  1  synchronous frame abort; discards the partial frame
Alu_ready  input  1  downstream registers/ALU can take a new frame
A_out  output  WIDTH  staged operand A
B_out  output  WIDTH  staged operand B
Op_out  output  OPW  staged opcode
Load_en  output  1  one-cycle pulse; downstream registers capture A_out/B_out/Op_out
Err  output  1  one-cycle pulse on an illegal opcode
Frame_cnt  output  8  count of committed frames, wraps 255->0

Behaviour:
- Reset (Rst_n low, asynchronous): state=S_OP; A_out/B_out/Op_out=0; Load_en=0; Err=0; Frame_cnt=0; In_ready=1 once reset is released.
- Accept: a word transfers on a rising Clk when In_valid && In_ready.
- In_ready = 1 in S_OP, S_A and S_B; 0 in S_COMMIT. It is decoded combinationally from the state only and never depends on In_valid.
- S_OP, on accept:
  - if In_data[OPW-1:0] < NUM_OPS: latch Op_out; go to S_A.
  - otherwise: pulse Err for the next cycle; Op_out unchanged; stay in S_OP.
  - In_data bits above OPW are ignored.
- S_A, on accept: latch A_out; go to S_B.
- S_B, on accept: latch B_out; go to S_COMMIT.
- S_COMMIT:
  - if Alu_ready: Load_en=1 for exactly one cycle (registered output, asserted the cycle after the decision); Frame_cnt += 1; go to S_OP.
  - else: hold with outputs stable; Load_en=0.
- Latency: Load_en is high no earlier than 1 cycle after the B word is accepted when Alu_ready is already high.
- Load_en and In_ready: the cycle Load_en is high the loader is already back in S_OP, so In_ready=1 and the next opcode can be accepted. Back-to-back frames therefore need 4 cycles each.
- Staged outputs: A_out/B_out/Op_out hold their values until overwritten by a later accept. They are valid for capture whenever Load_en=1.
- Abort:
  - synchronous, with priority over accept and over commit in the same cycle.
  - from any state it returns to S_OP.
  - no Load_en, no Frame_cnt increment, staged outputs unchanged.
  - Abort in S_OP is a no-op; an In_valid word offered in the same cycle is dropped.
- Reset mid-frame: all state is cleared immediately; the partial frame is lost; no Load_en is generated.
- In_data while In_valid is low is don't-care. No output is ever driven to X after reset.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding typedef (S_OP, S_A, S_B, S_COMMIT; 2 bits)
  - NUM_OPS and OPW defaults
  - opcode constants shared with the ALU
- No sub-module is required. Operand staging reuses the team's existing enable register instance per field (A, B, Op), with its enable tied to the per-state accept strobe.

Test Plan:
- Reset release, then send words 3, 5, 9 with Alu_ready=1 -> Op_out=3, A_out=5, B_out=9; Load_en high for exactly 1 cycle, 1 cycle after the B accept; Frame_cnt=1.
- Opcode word 7 (NUM_OPS=6) -> Err pulse 1 cycle; state stays S_OP; the next words 2, 1, 1 commit a frame with Op_out=2.
- Frame 1, 4, 4 with Alu_ready=0 for 5 cycles after the B accept -> In_ready=0 and Load_en=0 throughout; Load_en pulses 1 cycle after Alu_ready rises; In_valid=1 during the hold transfers nothing.
- Abort asserted together with In_valid on the B word of frame 0, 6, 6 -> no Load_en; state S_OP; B_out keeps its previous value; Frame_cnt unchanged.
- Rst_n pulsed low asynchronously mid-clock while in S_B -> all outputs 0 immediately; no Load_en after release; a fresh frame commits normally.
- 256 back-to-back frames with In_valid held high and Alu_ready=1 -> one Load_en every 4 cycles; Frame_cnt wraps to 0.
